// File: rtl/seg_display_mux_pkg.sv
// Shared types and constants for the calculator display path.
// Digit indices run left (sign) to right (hundredths).
package calc_disp_pkg;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_e;

  typedef logic [6:0] seg_t;

  localparam logic [2:0] DIG_SIGN   = 3'd0;
  localparam logic [2:0] DIG_TENS   = 3'd1;
  localparam logic [2:0] DIG_UNITS  = 3'd2;
  localparam logic [2:0] DIG_TENTHS = 3'd3;
  localparam logic [2:0] DIG_HUND   = 3'd4;

  localparam seg_t SEG_OFF      = 7'b0000000;
  localparam seg_t ZERO_PAT_DEF = 7'b0111111;

  typedef struct packed {
    seg_t sign;
    seg_t tens;
    seg_t units;
    seg_t tenths;
    seg_t hund;
  } digits_t;

  // an[4] is the sign digit, so index 0 maps to the MSB
  function automatic logic [4:0] dig_anode(
    input logic [2:0] idx
  );
    return 5'b10000 >> idx;
  endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// Digit-pattern bundle from the calculator FSM and the
// multiplexed display pins driven back out.
interface seg_display_mux_if;
  import calc_disp_pkg::*;

  seg_t       sign;
  seg_t       tens;
  seg_t       units;
  seg_t       tenths;
  seg_t       hundredths;
  logic       blank_lz;
  logic [4:0] an;
  seg_t       seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output sign,
    output tens,
    output units,
    output tenths,
    output hundredths,
    output blank_lz,
    input  an,
    input  seg,
    input  dp,
    input  frame_tick
  );

  modport slave (
    input  sign,
    input  tens,
    input  units,
    input  tenths,
    input  hundredths,
    input  blank_lz,
    output an,
    output seg,
    output dp,
    output frame_tick
  );

endinterface

// File: rtl/seg_display_mux_scan_timer.sv
// Blank/drive scan sequencer: walks the five digits and
// flags the shadow-load slot at the start of each frame.
module scan_timer
  import calc_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  output state_e     state_o,
  output logic [2:0] idx_o,
  output logic       load_o
);

  // A zero-length blank still keeps one cycle for the load slot
  localparam int unsigned BLEN =
    (BLANK_CYCLES > 0) ? BLANK_CYCLES : 1;
  localparam int unsigned M1 =
    (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CMAX = (M1 > 2) ? M1 : 2;
  localparam int CW = $clog2(CMAX);

  localparam logic [CW-1:0] B_LAST = CW'(BLEN - 1);
  localparam logic [CW-1:0] D_LAST = CW'(REFRESH_DIV - 1);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (1'b1)
      (state_q == S_BLANK): begin
        if (cnt_q == B_LAST) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end
      end
      (state_q == S_DRIVE): begin
        if (cnt_q == D_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == DIG_HUND) ?
                    DIG_SIGN : idx_q + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BLANK;
      idx_q   <= DIG_SIGN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign idx_o   = idx_q;
  assign load_o  = (state_q == S_BLANK) &&
                   (idx_q == DIG_SIGN) &&
                   (cnt_q == '0);

endmodule

// File: rtl/seg_display_mux.sv
// Five-digit multiplexed 7-segment driver with per-frame
// shadowing, inter-digit blanking and leading-zero blanking.
module seg_display_mux
  import calc_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter logic [6:0]  ZERO_PAT     = ZERO_PAT_DEF
) (
  input logic              clk,
  input logic              rst_n,
  seg_display_mux_if.slave bus
);

  localparam logic INV = ACTIVE_LOW;

  state_e     state;
  logic [2:0] idx;
  logic       load;

  scan_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_o (state),
    .idx_o   (idx),
    .load_o  (load)
  );

  digits_t    sh_q, sh_d;
  logic       lz_q, lz_d;
  seg_t       seg_raw;
  logic       lz_hit;
  logic [4:0] an_h;
  seg_t       seg_h;
  logic       dp_h;
  logic [4:0] an_q, an_d;
  seg_t       seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       ft_q;

  // Inputs are only sampled in the load slot so a frame never tears
  always_comb begin
    sh_d = sh_q;
    lz_d = lz_q;
    if (load) begin
      sh_d.sign   = bus.sign;
      sh_d.tens   = bus.tens;
      sh_d.units  = bus.units;
      sh_d.tenths = bus.tenths;
      sh_d.hund   = bus.hundredths;
      lz_d        = bus.blank_lz;
    end
  end

  always_comb begin
    seg_raw = SEG_OFF;
    case (idx)
      DIG_SIGN:   seg_raw = sh_q.sign;
      DIG_TENS:   seg_raw = sh_q.tens;
      DIG_UNITS:  seg_raw = sh_q.units;
      DIG_TENTHS: seg_raw = sh_q.tenths;
      DIG_HUND:   seg_raw = sh_q.hund;
      default:    seg_raw = SEG_OFF;
    endcase
  end

  assign lz_hit = (idx == DIG_TENS) && lz_q &&
                  (sh_q.tens == ZERO_PAT);

  always_comb begin
    an_h  = '0;
    seg_h = SEG_OFF;
    dp_h  = 1'b0;
    if (state == S_DRIVE) begin
      an_h  = dig_anode(idx);
      seg_h = lz_hit ? SEG_OFF : seg_raw;
      dp_h  = (idx == DIG_UNITS);
    end
  end

  assign an_d  = an_h ^ {5{INV}};
  assign seg_d = seg_h ^ {7{INV}};
  assign dp_d  = dp_h ^ INV;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
      lz_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      lz_q <= lz_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= {5{INV}};
      seg_q <= {7{INV}};
      dp_q  <= INV;
      ft_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      ft_q  <= load;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Three builds side by side (blanked/active-low, no blank,
// active-high) checked against a time-based frame model.
module tb_seg_display_mux;
  import calc_disp_pkg::*;

  localparam int R  = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg_display_mux_if i0 ();
  seg_display_mux_if i1 ();
  seg_display_mux_if i2 ();

  seg_display_mux #(
    .REFRESH_DIV(R), .BLANK_CYCLES(2),
    .ACTIVE_LOW(1'b1), .ZERO_PAT(7'h3F)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));

  seg_display_mux #(
    .REFRESH_DIV(R), .BLANK_CYCLES(0),
    .ACTIVE_LOW(1'b1), .ZERO_PAT(7'h3F)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  seg_display_mux #(
    .REFRESH_DIV(R), .BLANK_CYCLES(2),
    .ACTIVE_LOW(1'b0), .ZERO_PAT(7'h3F)
  ) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

  logic [6:0]  din [5];
  logic        lz;
  logic [35:0] inp;
  logic [13:0] obs [NI];

  assign inp = {din[0], din[1], din[2], din[3], din[4], lz};
  assign {i0.sign, i0.tens, i0.units, i0.tenths,
          i0.hundredths, i0.blank_lz} = inp;
  assign {i1.sign, i1.tens, i1.units, i1.tenths,
          i1.hundredths, i1.blank_lz} = inp;
  assign {i2.sign, i2.tens, i2.units, i2.tenths,
          i2.hundredths, i2.blank_lz} = inp;

  assign obs[0] = {i0.an, i0.seg, i0.dp, i0.frame_tick};
  assign obs[1] = {i1.an, i1.seg, i1.dp, i1.frame_tick};
  assign obs[2] = {i2.an, i2.seg, i2.dp, i2.frame_tick};

  int ncmp = 0;
  int nbad = 0;
  int k = 0;
  int ftc = 0;
  logic [6:0] msh [NI][5];
  bit         mlz [NI];

  function automatic int bcy(input int i);
    return (i == 1) ? 0 : 2;
  endfunction

  function automatic bit alw(input int i);
    return i != 2;
  endfunction

  function automatic int blen(input int i);
    return (bcy(i) > 0) ? bcy(i) : 1;
  endfunction

  function automatic int per(input int i);
    return blen(i) + R;
  endfunction

  // Pins at period k show the scan position of period k-1
  function automatic logic [13:0] model(input int i);
    int j, p, slot, w;
    logic [4:0] an;
    logic [6:0] sg;
    logic dp, ft;
    an = '0; sg = '0; dp = 1'b0; ft = 1'b0;
    if (k > 0) begin
      j = k - 1;
      p = j % (5 * per(i));
      slot = p / per(i);
      w = p % per(i);
      ft = (p == 0);
      if (w >= blen(i)) begin
        an[4 - slot] = 1'b1;
        if (slot == 1 && mlz[i] && msh[i][1] == 7'h3F)
          sg = 7'h00;
        else
          sg = msh[i][slot];
        dp = (slot == 2);
      end
    end
    if (alw(i)) begin
      an = ~an; sg = ~sg; dp = ~dp;
    end
    return {an, sg, dp, ft};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int d = 0; d < 5; d++) msh[i][d] = 7'h00;
      mlz[i] = 1'b0;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nbad++;
      $error("FAIL %s k=%0d got %h want %h", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    logic [13:0] e;
    logic [4:0] ah;
    for (int i = 0; i < NI; i++) begin
      e = model(i);
      ncmp++;
      assert (obs[i] === e) else begin
        nbad++;
        $error("FAIL pins[%0d] k=%0d got %h want %h",
               i, k, obs[i], e);
      end
      ah = alw(i) ? ~obs[i][13:9] : obs[i][13:9];
      ncmp++;
      assert ($onehot0(ah)) else begin
        nbad++;
        $error("FAIL onehot[%0d] k=%0d got %b want <=1 lit",
               i, k, ah);
      end
    end
    if (k >= 1 && k <= 90 && obs[0][0] === 1'b1) ftc++;
    for (int i = 0; i < NI; i++) begin
      if (k % (5 * per(i)) == 0) begin
        for (int d = 0; d < 5; d++) msh[i][d] = din[d];
        mlz[i] = lz;
      end
    end
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int n);
    while (k < n) tick();
  endtask

  task automatic set_base();
    din[0] = 7'h00; din[1] = 7'h06; din[2] = 7'h5B;
    din[3] = 7'h66; din[4] = 7'h6D; lz = 1'b0;
  endtask

  initial begin
    set_base();
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_u0", 32'(obs[0]), 32'({5'h1F, 7'h7F, 1'b1, 1'b0}));
    chk("rst_u2", 32'(obs[2]), 32'({5'h00, 7'h00, 1'b0, 1'b0}));
    rst_n = 1'b1;
    k = 0;

    run_to(1);
    chk("ft_first_u0", 32'(obs[0][0]), 32'd1);
    chk("ft_first_u1", 32'(obs[1][0]), 32'd1);
    run_to(2);
    chk("ft_drop_u0", 32'(obs[0][0]), 32'd0);
    run_to(3);
    chk("sign_u0", 32'(obs[0]), 32'({5'b01111, 7'h7F, 1'b1, 1'b0}));
    run_to(15);
    chk("units_u0", 32'(obs[0]), 32'({5'b11011, 7'h24, 1'b0, 1'b0}));
    chk("units_u1", 32'(obs[1]), 32'({5'b11011, 7'h24, 1'b0, 1'b0}));
    chk("units_u2", 32'(obs[2]), 32'({5'b00100, 7'h5B, 1'b1, 1'b0}));

    run_to(22);
    din[2] = 7'h7F;
    run_to(24);
    chk("tenths_u0", 32'(obs[0][13:9]), 32'(5'b11101));
    run_to(45);
    chk("units_new_u0", 32'(obs[0]), 32'({5'b11011, 7'h00, 1'b0, 1'b0}));
    run_to(91);
    chk("ft_count", 32'(ftc), 32'd3);

    run_to(95);
    din[1] = 7'h3F;
    lz = 1'b1;
    run_to(130);
    chk("lz_on_u0", 32'(obs[0]), 32'({5'b10111, 7'h7F, 1'b1, 1'b0}));
    chk("lz_on_u2", 32'(obs[2]), 32'({5'b01000, 7'h00, 1'b0, 1'b0}));
    run_to(131);
    lz = 1'b0;
    run_to(160);
    chk("lz_off_u0", 32'(obs[0]), 32'({5'b10111, 7'h40, 1'b1, 1'b0}));

    while (k < 430) begin
      if ($urandom_range(0, 7) == 0)
        din[$urandom_range(0, 4)] = 7'($urandom);
      if ($urandom_range(0, 15) == 0) lz = 1'($urandom);
      if ($urandom_range(0, 15) == 0) din[1] = 7'h3F;
      tick();
    end

    run_to(436);
    chk("pre_rst_u0", 32'(obs[0][13:9]), 32'(5'b11011));
    rst_n = 1'b0;
    #1;
    chk("async_u0", 32'(obs[0]), 32'({5'h1F, 7'h7F, 1'b1, 1'b0}));
    chk("async_u1", 32'(obs[1]), 32'({5'h1F, 7'h7F, 1'b1, 1'b0}));
    chk("async_u2", 32'(obs[2]), 32'({5'h00, 7'h00, 1'b0, 1'b0}));
    @(negedge clk);
    set_base();
    model_reset();
    rst_n = 1'b1;
    k = 0;
    run_to(1);
    chk("ft_restart", 32'(obs[0][0]), 32'd1);
    run_to(3);
    chk("sign_restart", 32'(obs[0]), 32'({5'b01111, 7'h7F, 1'b1, 1'b0}));
    run_to(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
